// File: rtl/siso_pkg.sv
// Shared definitions for the serializer front end and the downstream shift chain.
package siso_pkg;

    // Word width shared with the four-stage downstream chain.
    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit-counter width able to hold values 0..width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: WIDTH-bit words in over valid/ready,
// one bit per clock out on sout, back-to-back words without idle gaps.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_serializer
    import siso_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif
    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             sout_d, sout_valid_d, frame_start_d, busy_d;
    logic             accept, last_cycle;
    logic             first_bit, cur_bit;
    logic [WIDTH-1:0] din_sh, sreg_sh;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    // State and registered outputs; synchronous reset aborts any word in flight.
    always_ff @(posedge Clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sreg_q      <= '0;
            sout        <= 1'b0;
            sout_valid  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sreg_q      <= sreg_d;
            sout        <= sout_d;
            sout_valid  <= sout_valid_d;
            frame_start <= frame_start_d;
            busy        <= busy_d;
`ifdef PISO_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    // Next-state and next-output logic. sout is registered, so the bit
    // presented next cycle is chosen here and the remainder kept in sreg.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sreg_d        = sreg_q;
        sout_d        = 1'b0;
        sout_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        busy_d        = 1'b0;
`ifdef PISO_PARITY_EN
        par_d         = par_q;
`endif

        if (MSB_FIRST) begin
            first_bit = din[WIDTH-1];
            din_sh    = {din[WIDTH-2:0], 1'b0};
            cur_bit   = sreg_q[WIDTH-1];
            sreg_sh   = {sreg_q[WIDTH-2:0], 1'b0};
        end else begin
            first_bit = din[0];
            din_sh    = {1'b0, din[WIDTH-1:1]};
            cur_bit   = sreg_q[0];
            sreg_sh   = {1'b0, sreg_q[WIDTH-1:1]};
        end

        last_cycle = (state_q == SHIFT) && (cnt_q == LAST_CNT);
        din_ready  = (state_q == IDLE) || last_cycle;
        accept     = din_valid && din_ready;

        if (accept) begin
            state_d       = SHIFT;
            cnt_d         = '0;
            sreg_d        = din_sh;
            sout_d        = first_bit;
            sout_valid_d  = 1'b1;
            frame_start_d = 1'b1;
            busy_d        = 1'b1;
`ifdef PISO_PARITY_EN
            par_d         = ^din;
`endif
        end else if (state_q == SHIFT) begin
            if (last_cycle) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d        = cnt_q + CW'(1);
                sreg_d       = sreg_sh;
                sout_d       = cur_bit;
                sout_valid_d = 1'b1;
                busy_d       = 1'b1;
`ifdef PISO_PARITY_EN
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sout_d = par_q;
                end
`endif
            end
        end
    end

endmodule
